useq_uart_bridge: RTL

Host-side bridge for the useq FIFO port. It drives the FIFO side that useq does not: it pushes bytes received on a UART RX line into useq with write_fifo/fifo_in, and it pops bytes from useq with read_fifo/fifo_out and serialises them on a UART TX line. It sits in top between the board pins and the useq instance, and replaces the static fifo_in/read_fifo/write_fifo registers.

---
 rtl/useq_uart_bridge.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/useq_uart_bridge.sv
// useq_uart_bridge
//   Host-side bridge for the useq FIFO port. Bytes received on uart_rx are
//   pushed into useq (write_fifo/fifo_in). Bytes popped from useq
//   (read_fifo/fifo_out) are sent on uart_tx. The frame format is 8N1.
//
// Ports
//   clk          system clock (posedge)
//   rst_n        asynchronous active-low reset
//   uart_rx      serial input; idles high; asynchronous to clk
//   uart_tx      serial output; idles high; driven from a flop
//   fifo_out     useq FIFO head byte (first-word fall-through)
//   fifo_empty   useq FIFO has no byte for the host
//   fifo_full    useq FIFO cannot accept a byte
//   read_fifo    one-cycle pop strobe (registered)
//   write_fifo   one-cycle push strobe (registered)
//   fifo_in      push data; held after the push
//   rx_overrun   sticky: a received byte was dropped
//   framing_err  one-cycle pulse: a bad stop bit was seen
module useq_uart_bridge #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] fifo_out,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  output logic       read_fifo,
  output logic       write_fifo,
  output logic [7:0] fifo_in,
  output logic       rx_overrun,
  output logic       framing_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  // The TX state register lags uart_tx by one cycle. Leaving STOP one count
  // early makes the stop bit exactly CLKS_PER_BIT long on the pin.
  localparam logic [15:0] STOP_LAST = 16'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- RX engine ----------------
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        framing_q, framing_d;
  logic        rx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      framing_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      framing_q  <= framing_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    framing_d  = 1'b0;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_sync_q) rx_done   = 1'b1;
          else           framing_d = 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- Holding register and push ----------------
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       write_q, write_d;
  logic [7:0] fifo_in_q, fifo_in_d;
  logic       overrun_q, overrun_d;
  logic       can_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      write_q    <= 1'b0;
      fifo_in_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      write_q    <= write_d;
      fifo_in_q  <= fifo_in_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    write_d    = 1'b0;
    fifo_in_d  = fifo_in_q;
    overrun_d  = overrun_q;
    // Gating on write_q keeps the push strobe from ever lasting 2 cycles.
    can_push   = !fifo_full && !write_q;
    if (hold_vld_q) begin
      if (can_push) begin
        write_d    = 1'b1;
        fifo_in_d  = hold_q;
        hold_vld_d = 1'b0;
      end
      if (rx_done) overrun_d = 1'b1;
    end else if (rx_done) begin
      // Bypass the holding register so the push lands one cycle after the
      // stop-bit sample.
      if (can_push) begin
        write_d   = 1'b1;
        fifo_in_d = rx_sh_q;
      end else begin
        hold_d     = rx_sh_q;
        hold_vld_d = 1'b1;
      end
    end
  end

  // ---------------- TX engine ----------------
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        read_q, read_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      read_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      read_q     <= read_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    read_d     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        // Pops happen only here, so the one-cycle lag of fifo_empty after a
        // pop can never cause a second pop.
        if (!fifo_empty) begin
          read_d     = 1'b1;
          tx_sh_d    = fifo_out;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q == STOP_LAST) tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign uart_tx     = tx_q;
  assign read_fifo   = read_q;
  assign write_fifo  = write_q;
  assign fifo_in     = fifo_in_q;
  assign rx_overrun  = overrun_q;
  assign framing_err = framing_q;

endmodule
